// File: rtl/inert_pkg.sv
// Shared types and SPI command tables for the inertial sensor front end.
// Imported by the RTL and the testbench.
package inert_pkg;

    typedef enum logic [2:0] {
        INIT_WAIT,
        CFG,
        CFG_WAIT,
        IDLE,
        RD,
        RD_WAIT,
        VLD
    } state_t;

    localparam logic [15:0] CFG_CMD [4] = '{
        16'h0D02, 16'h1053, 16'h1150, 16'h1460
    };

    localparam logic [15:0] RD_CMD [4] = '{
        16'hA200, 16'hA300, 16'hAC00, 16'hAD00
    };

endpackage

// File: rtl/inert_int_sync.sv
// Two-flop synchroniser for the sensor INT line with a one-cycle
// rising-edge pulse on the synchronised level.
module inert_int_sync (
    input  logic clk,
    input  logic rst,
    input  logic INT,
    output logic rise
);

    logic s1, s2, s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= INT;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/inert_intf.sv
// SPI front end for the 6-axis inertial sensor: configure, then read one
// sample per data-ready edge. Optional watchdog: define INERT_WDOG_EN.
module inert_intf
    import inert_pkg::*;
#(
    parameter int INIT_DLY_W = 16
`ifdef INERT_WDOG_EN
    ,
    parameter int WDOG_CYC = 2000000
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        INT,
    output logic        wrt,
    output logic [15:0] cmd,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic [15:0] ptch_rt,
    output logic [15:0] AZ,
    output logic        vld,
    output logic        stale
);

    localparam logic [INIT_DLY_W-1:0] TMR_ONE = INIT_DLY_W'(1);
    // Leave INIT_WAIT as the timer steps onto all-ones.
    localparam logic [INIT_DLY_W-1:0] TMR_PRE = ~TMR_ONE;

    state_t                state, nxt;
    logic [INIT_DLY_W-1:0] timer;
    logic [1:0]            idx;
    logic                  pending;
    logic                  int_rise;
    logic [15:0]           cmd_q;
    logic [7:0]            byte_q [3];
    logic                  last_idx;
    logic                  rd_fin;
    logic                  cfg_fin;
    logic [7:0]            rd_hi_unused;

    assign rd_hi_unused = rd_data[15:8];
    assign last_idx     = (idx == 2'd3);
    assign rd_fin       = (state == RD_WAIT) && done && last_idx;
    assign cfg_fin      = (state == CFG_WAIT) && done && last_idx;

    inert_int_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .INT  (INT),
        .rise (int_rise)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= INIT_WAIT;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            INIT_WAIT: if (timer == TMR_PRE) nxt = CFG;
            CFG:       nxt = CFG_WAIT;
            CFG_WAIT:  if (done) nxt = last_idx ? IDLE : CFG;
            IDLE:      if (int_rise || pending) nxt = RD;
            RD:        nxt = RD_WAIT;
            RD_WAIT:   if (done) nxt = last_idx ? VLD : RD;
            VLD:       nxt = IDLE;
            default:   nxt = INIT_WAIT;
        endcase
    end

    always_comb begin
        wrt = 1'b0;
        vld = 1'b0;
        cmd = cmd_q;
        unique case (1'b1)
            (state == CFG): begin
                wrt = 1'b1;
                cmd = CFG_CMD[idx];
            end
            (state == RD): begin
                wrt = 1'b1;
                cmd = RD_CMD[idx];
            end
            (state == VLD): vld = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer   <= '0;
            idx     <= 2'd0;
            pending <= 1'b0;
            cmd_q   <= 16'h0000;
            ptch_rt <= 16'h0000;
            AZ      <= 16'h0000;
        end else begin
            if (state == INIT_WAIT) timer <= timer + TMR_ONE;
            if ((state == CFG_WAIT || state == RD_WAIT) && done)
                idx <= idx + 2'd1;
            if (cfg_fin || state == IDLE) pending <= 1'b0;
            else if (int_rise)            pending <= 1'b1;
            if (state == CFG) cmd_q <= CFG_CMD[idx];
            if (state == RD)  cmd_q <= RD_CMD[idx];
            // Last byte comes straight off the bus so both words land together.
            if (rd_fin) begin
                ptch_rt <= {byte_q[1], byte_q[0]};
                AZ      <= {rd_data[7:0], byte_q[2]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == RD_WAIT && done && !last_idx)
            byte_q[idx] <= rd_data[7:0];
    end

`ifdef INERT_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYC + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            wd_run;
    logic            stale_q;

    assign wd_run = (state == IDLE) || (state == RD) ||
                    (state == RD_WAIT) || (state == VLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt  <= '0;
            stale_q <= 1'b0;
        end else begin
            if (!wd_run || state == VLD)
                wd_cnt <= '0;
            else if (wd_cnt != WD_W'(WDOG_CYC))
                wd_cnt <= wd_cnt + WD_W'(1);
            if (rd_fin)
                stale_q <= 1'b0;
            else if (wd_run && wd_cnt == WD_W'(WDOG_CYC - 1))
                stale_q <= 1'b1;
        end
    end

    assign stale = stale_q;
`else
    assign stale = 1'b0;
`endif

endmodule

// File: tb/tb_inert_intf.sv
// Scoreboard bench for inert_intf: SPI slave model checks command order,
// a monitor checks every sample against the expected queue.
module tb_inert_intf;
    import inert_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        INT = 1'b0;
    logic        wrt;
    logic [15:0] cmd;
    logic        done = 1'b0;
    logic [15:0] rd_data = 16'h0000;
    logic [15:0] ptch_rt;
    logic [15:0] AZ;
    logic        vld;
    logic        stale;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_vld = 0;
    int n_wrt = 0;
    int last_rd3_done = -10;

    logic [15:0] exp_cmd_q [$];
    logic [7:0]  rd_q [$];
    logic [31:0] exp_out_q [$];

    bit          busy = 0;
    bit          prev_wrt = 0;
    bit          prev_vld = 0;
    int          dly = 0;
    logic [15:0] cur_cmd = 16'h0000;
    logic [7:0]  cur_byte = 8'h00;
    logic [31:0] cur_out = 32'h0;

    inert_intf #(
        .INIT_DLY_W (4)
`ifdef INERT_WDOG_EN
        ,
        .WDOG_CYC   (100)
`endif
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .INT     (INT),
        .wrt     (wrt),
        .cmd     (cmd),
        .done    (done),
        .rd_data (rd_data),
        .ptch_rt (ptch_rt),
        .AZ      (AZ),
        .vld     (vld),
        .stale   (stale)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // SPI slave: done 20 cycles after wrt, checks cmd order and stability.
    always begin
        @(posedge clk);
        #1;
        done    = 1'b0;
        rd_data = 16'hDE5A;
        if (rst) begin
            busy     = 0;
            prev_wrt = 0;
        end else begin
            if (wrt) begin
                n_wrt++;
                checks++;
                if (prev_wrt || busy) begin
                    errors++;
                    $display("FAIL wrt_overlap: wrt=1 prev=%0b busy=%0b",
                             prev_wrt, busy);
                end
                checks++;
                if (exp_cmd_q.size() == 0) begin
                    errors++;
                    $display("FAIL wrt_unexpected: cmd=%h want no wrt", cmd);
                end else begin
                    logic [15:0] e;
                    e = exp_cmd_q.pop_front();
                    if (cmd !== e) begin
                        errors++;
                        $display("FAIL cmd_order: got %h want %h", cmd, e);
                    end
                end
                cur_cmd  = cmd;
                cur_byte = (cmd[15] && rd_q.size() > 0) ?
                           rd_q.pop_front() : 8'h00;
                busy     = 1;
                dly      = 19;
            end else if (busy) begin
                checks++;
                if (cmd !== cur_cmd) begin
                    errors++;
                    $display("FAIL cmd_stable: got %h want %h", cmd, cur_cmd);
                end
                if (dly == 0) begin
                    done    = 1'b1;
                    rd_data = {8'hA5, cur_byte};
                    busy    = 0;
                    if (cur_cmd == RD_CMD[3]) last_rd3_done = cyc;
                end else begin
                    dly--;
                end
            end
            prev_wrt = wrt;
        end
    end

    // Output monitor: pops expected sample on vld, else outputs must hold.
    always begin
        @(posedge clk);
        #1;
        if (rst) begin
            cur_out = 32'h0;
            checks++;
            if ({ptch_rt, AZ} !== 32'h0 || vld !== 1'b0) begin
                errors++;
                $display("FAIL rst_outputs: got %h vld=%b want 0",
                         {ptch_rt, AZ}, vld);
            end
        end else if (vld) begin
            n_vld++;
            checks++;
            if (exp_out_q.size() == 0) begin
                errors++;
                $display("FAIL vld_unexpected: got %h", {ptch_rt, AZ});
            end else begin
                cur_out = exp_out_q.pop_front();
                if ({ptch_rt, AZ} !== cur_out) begin
                    errors++;
                    $display("FAIL sample: got %h want %h",
                             {ptch_rt, AZ}, cur_out);
                end
            end
            checks++;
            if (cyc != last_rd3_done + 1 || prev_vld) begin
                errors++;
                $display("FAIL vld_timing: vld at %0d want %0d",
                         cyc, last_rd3_done + 1);
            end
        end else begin
            checks++;
            if ({ptch_rt, AZ} !== cur_out) begin
                errors++;
                $display("FAIL hold: got %h want %h", {ptch_rt, AZ}, cur_out);
            end
        end
        prev_vld = vld;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors + 1);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_cfg();
        for (int i = 0; i < 4; i++) exp_cmd_q.push_back(CFG_CMD[i]);
    endtask

    task automatic push_burst(input logic [7:0] b0, b1, b2, b3);
        for (int i = 0; i < 4; i++) exp_cmd_q.push_back(RD_CMD[i]);
        rd_q.push_back(b0);
        rd_q.push_back(b1);
        rd_q.push_back(b2);
        rd_q.push_back(b3);
        exp_out_q.push_back({b1, b0, b3, b2});
    endtask

    task automatic pulse_int();
        INT = 1'b1;
        repeat (3) tick();
        INT = 1'b0;
    endtask

    // Called right after a reset edge: first wrt must come 15 edges later.
    task automatic check_first_wrt(input string tag);
        int n;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (wrt) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n != 15) begin
            errors++;
            $display("FAIL %s_first_wrt: cycle %0d want 15", tag, n);
        end
    endtask

    task automatic wait_cfg(input string tag);
        int k;
        k = 0;
        while ((exp_cmd_q.size() != 0 || busy) && k < 400) begin
            tick();
            k++;
        end
        checks++;
        if (k >= 400) begin
            errors++;
            $display("FAIL %s_cfg_done: %0d cmds left want 0",
                     tag, exp_cmd_q.size());
        end
        tick();
    endtask

    task automatic wait_vld(input int target, input string tag);
        int k;
        k = 0;
        while (n_vld < target && k < 400) begin
            tick();
            k++;
        end
        checks++;
        if (n_vld != target) begin
            errors++;
            $display("FAIL %s_vld_count: got %0d want %0d", tag, n_vld, target);
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++;
        if (wrt !== 1'b0 || vld !== 1'b0 || cmd !== 16'h0 ||
            ptch_rt !== 16'h0 || AZ !== 16'h0 || stale !== 1'b0) begin
            errors++;
            $display("FAIL reset: wrt=%b vld=%b cmd=%h p=%h a=%h st=%b want 0",
                     wrt, vld, cmd, ptch_rt, AZ, stale);
        end
    endtask

    task automatic test_init();
        push_cfg();
        rst = 1'b0;
        check_first_wrt("init");
        pulse_int();
        wait_cfg("init");
        repeat (40) tick();
        checks++;
        if (cmd !== 16'h1460 || n_wrt != 4 || n_vld != 0) begin
            errors++;
            $display("FAIL init_idle: cmd=%h wrts=%0d vlds=%0d want 1460 4 0",
                     cmd, n_wrt, n_vld);
        end
    endtask

    task automatic test_sample(input logic [7:0] b0, b1, b2, b3,
                               input string tag);
        int n0;
        n0 = n_vld;
        push_burst(b0, b1, b2, b3);
        pulse_int();
        wait_vld(n0 + 1, tag);
        repeat (5) tick();
    endtask

    task automatic test_level();
        int n0;
        n0 = n_vld;
        push_burst(8'h11, 8'h22, 8'h33, 8'h44);
        INT = 1'b1;
        repeat (1000) tick();
        INT = 1'b0;
        repeat (10) tick();
        checks++;
        if (n_vld != n0 + 1 || exp_cmd_q.size() != 0) begin
            errors++;
            $display("FAIL level_int: bursts=%0d want 1", n_vld - n0);
        end
    endtask

    task automatic test_back_to_back();
        int n0, w0, v, k;
        n0 = n_vld;
        w0 = n_wrt;
        push_burst(8'hC1, 8'hC2, 8'hC3, 8'hC4);
        push_burst(8'hD1, 8'hD2, 8'hD3, 8'hD4);
        INT = 1'b1;
        k = 0;
        while (n_wrt == w0 && k < 20) begin
            tick();
            k++;
        end
        INT = 1'b0;
        repeat (3) tick();
        pulse_int();
        wait_vld(n0 + 1, "b2b_first");
        v = cyc;
        k = 0;
        while (!wrt && k < 6) begin
            tick();
            k++;
        end
        checks++;
        if (!wrt || cyc - v > 2) begin
            errors++;
            $display("FAIL b2b_restart: wrt %0d cycles after vld want <=2",
                     cyc - v);
        end
        wait_vld(n0 + 2, "b2b_second");
        repeat (5) tick();
    endtask

    task automatic test_rst_mid();
        int k;
        push_burst(8'h01, 8'h02, 8'h03, 8'h04);
        pulse_int();
        k = 0;
        while (!(busy && cur_cmd == RD_CMD[2]) && k < 200) begin
            tick();
            k++;
        end
        repeat (5) tick();
        rst = 1'b1;
        exp_cmd_q.delete();
        rd_q.delete();
        exp_out_q.delete();
        tick();
        checks++;
        if (wrt !== 1'b0 || vld !== 1'b0 ||
            ptch_rt !== 16'h0 || AZ !== 16'h0) begin
            errors++;
            $display("FAIL rst_mid: wrt=%b vld=%b p=%h a=%h want 0",
                     wrt, vld, ptch_rt, AZ);
        end
        push_cfg();
        rst = 1'b0;
        check_first_wrt("rst_mid");
        wait_cfg("rst_mid");
    endtask

    task automatic test_stale();
`ifdef INERT_WDOG_EN
        int n, n0, k;
        checks++;
        if (stale !== 1'b0) begin
            errors++;
            $display("FAIL stale_start: got %b want 0", stale);
        end
        n = 0;
        while (!stale && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n < 90 || n > 105) begin
            errors++;
            $display("FAIL stale_rise: after %0d cycles want ~100", n);
        end
        n0 = n_vld;
        push_burst(8'h5A, 8'h6B, 8'h7C, 8'h8D);
        pulse_int();
        k = 0;
        while (n_vld == n0 && k < 400) begin
            tick();
            k++;
        end
        checks++;
        if (n_vld != n0 + 1 || stale !== 1'b0) begin
            errors++;
            $display("FAIL stale_clear: stale=%b vlds=%0d want 0 1",
                     stale, n_vld - n0);
        end
`else
        int bad;
        bad = 0;
        repeat (200) begin
            tick();
            if (stale !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stale_tied: %0d cycles with stale!=0 want 0", bad);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_init();
        test_sample(8'h34, 8'h12, 8'h78, 8'h56, "basic");
        test_sample(8'h00, 8'hFF, 8'hF0, 8'hFF, "negative");
        test_level();
        test_back_to_back();
        test_rst_mid();
        test_stale();
        repeat (5) tick();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
